// File: rtl/instr_fetch_unit.sv
// Instruction fetch controller: turns the PC address into an instruction-memory
// read handshake, holds the fetched word for decode and strobes pc_count back
// to the PC. Redirects during a fetch mark the in-flight read as stale instead
// of abandoning it.
// Optional feature: define FETCH_TIMEOUT_EN to enable the REQ timeout counter
// and the sticky fetch_error / ERROR state.
module instr_fetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_address,
    input  logic        redirect,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] fetch_pc,
    output logic        pc_count,
    output logic        fetch_error
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StReq   = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;
    localparam logic [1:0] StError = 2'd3;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    logic [1:0]  state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        discard_q, discard_d;
    logic        timeout_hit;

`ifdef FETCH_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    // Count REQ cycles without an ack; REQ is only entered from IDLE, so clearing
    // in IDLE is the same as clearing on REQ entry. Redirects do not touch it.
    always_comb begin
        tmo_cnt_d   = tmo_cnt_q;
        timeout_hit = 1'b0;
        if (state_q == StIdle) begin
            tmo_cnt_d = 16'd0;
        end else if (state_q == StReq && !mem_ack) begin
            tmo_cnt_d   = tmo_cnt_q + 16'd1;
            timeout_hit = (tmo_cnt_d == 16'(TIMEOUT_CYCLES));
        end
    end

    // Timeout counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= 16'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign fetch_error = (state_q == StError);
`else
    assign timeout_hit = 1'b0;
    assign fetch_error = 1'b0;
`endif

    // Fetch sequencing: IDLE latches the PC, REQ waits for the ack, HOLD offers the word
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        instr_d    = instr_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        case (state_q)
            StIdle: begin
                // On a redirect edge pc_address is still the old value, so wait a cycle
                if (!redirect) begin
                    mem_addr_d = pc_address;
                    state_d    = StReq;
                end
            end
            StReq: begin
                if (mem_ack) begin
                    if (discard_q || redirect) begin
                        state_d = StIdle;
                    end else begin
                        instr_d    = mem_rdata;
                        fetch_pc_d = mem_addr_q;
                        state_d    = StHold;
                    end
                end else if (timeout_hit) begin
                    state_d = StError;
                end else if (redirect) begin
                    // Let the memory finish, but throw the data away
                    discard_d = 1'b1;
                end
            end
            StHold: begin
                if (redirect || instr_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
        if (state_d == StIdle) begin
            discard_d = 1'b0;
        end
        mem_req_d = (state_d == StReq);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'd0;
            instr_q    <= 32'd0;
            fetch_pc_q <= 32'd0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign fetch_pc    = fetch_pc_q;
    // A redirect in HOLD kills the offer in the same cycle
    assign instr_valid = (state_q == StHold) & ~redirect;
    assign pc_count    = instr_valid & instr_ready;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a random run against a
// PC + memory model. Define FETCH_TIMEOUT_EN to also exercise the timeout.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_address;
    logic        redirect;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] fetch_pc;
    logic        pc_count;
    logic        fetch_error;

    instr_fetch_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_address (pc_address),
        .redirect   (redirect),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .fetch_pc   (fetch_pc),
        .pc_count   (pc_count),
        .fetch_error(fetch_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Environment model: architectural PC and memory timing
    logic [31:0] pc;
    int          lat;
    int          age;
    bit          rand_mode;
    bit          dead_data;
    bit          force_ack;
    bit          prev_req;
    logic [31:0] held_addr;
    int          hs_cnt;
    int          gap;
    int          max_gap;
    int          pulses;

    // Per-step samples
    logic [31:0] s_req, s_addr, s_valid, s_instr, s_fpc, s_cnt, s_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2108_000A;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_instr"}, instr, 32'd0);
        check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_fetch_pc"}, fetch_pc, 32'd0);
        check({tag, "_pc_count"}, 32'(pc_count), 32'd0);
        check({tag, "_fetch_error"}, 32'(fetch_error), 32'd0);
    endtask

    task automatic do_reset(input logic [31:0] start);
        rst         = 1'b0;
        redirect    = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'd0;
        instr_ready = 1'b0;
        pc          = start;
        pc_address  = start;
        age         = 0;
        prev_req    = 1'b0;
        force_ack   = 1'b0;
        dead_data   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // One clock cycle: drive inputs at negedge, check, then advance the models
    task automatic step(input logic redir, input logic [31:0] tgt, input logic rdy);
        @(negedge clk);
        redirect    = redir;
        instr_ready = rdy;
        mem_ack     = 1'b0;
        mem_rdata   = 32'd0;
        if ((mem_req && age >= lat) || force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = dead_data ? 32'hDEAD_BEEF : memval(mem_addr);
        end
        #1;
        s_req   = 32'(mem_req);
        s_addr  = mem_addr;
        s_valid = 32'(instr_valid);
        s_instr = instr;
        s_fpc   = fetch_pc;
        s_cnt   = 32'(pc_count);
        s_err   = 32'(fetch_error);
        check("valid_mask", 32'(instr_valid & redir), 32'd0);
        check("pc_count", 32'(pc_count), 32'(instr_valid & rdy & ~redir));
        if (instr_valid && rdy) begin
            // Whatever decode accepts must be the word at the current PC
            check("fetch_pc", fetch_pc, pc);
            check("instr", instr, memval(fetch_pc));
            hs_cnt++;
            gap = 0;
        end else begin
            gap++;
        end
        if (gap > max_gap) max_gap = gap;
        if (mem_req && !prev_req) check("req_addr", mem_addr, pc);
        if (mem_req && prev_req) check("addr_stable", mem_addr, held_addr);
        held_addr = mem_addr;
        prev_req  = mem_req;
        if (pc_count) pulses++;
        @(posedge clk);
        #1;
        if (mem_ack) begin
            age = 0;
            if (rand_mode) lat = $urandom_range(0, 4);
        end else if (s_req[0]) begin
            age++;
        end
        if (redir) pc = tgt;
        else if (s_cnt[0]) pc = pc + 32'd4;
        pc_address = pc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq;
        int nval;
        rand_mode = 1'b0;
        lat       = 0;
        hs_cnt    = 0;
        gap       = 0;
        max_gap   = 0;

        // Zero-wait fetch
        do_reset(32'h0040_0000);
        pulses = 0;
        step(1'b0, 32'd0, 1'b1);
        check("t1_idle_req", s_req, 32'd0);
        step(1'b0, 32'd0, 1'b1);
        check("t1_req", s_req, 32'd1);
        check("t1_addr", s_addr, 32'h0040_0000);
        step(1'b0, 32'd0, 1'b1);
        check("t1_valid", s_valid, 32'd1);
        check("t1_instr", s_instr, 32'h2108_000A);
        check("t1_fpc", s_fpc, 32'h0040_0000);
        step(1'b0, 32'd0, 1'b1);
        check("t1_idle2", s_req, 32'd0);
        check("t1_pulses", 32'(pulses), 32'd1);
        step(1'b0, 32'd0, 1'b1);
        check("t1_req2", s_req, 32'd1);
        check("t1_next_addr", s_addr, 32'h0040_0004);

        // Wait states and backpressure
        do_reset(32'h0040_0000);
        lat    = 5;
        pulses = 0;
        nreq   = 0;
        nval   = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 32'd0, (i == 10));
            nreq += int'(s_req);
            nval += int'(s_valid);
        end
        check("t2_req_cycles", 32'(nreq), 32'd6);
        check("t2_valid_cycles", 32'(nval), 32'd4);
        check("t2_pulses", 32'(pulses), 32'd1);

        // Redirect during REQ; stale data must not surface
        do_reset(32'h0040_0000);
        lat       = 3;
        dead_data = 1'b1;
        nval      = 0;
        for (int i = 0; i < 6; i++) begin
            step((i == 2), 32'h0040_0100, 1'b1);
            nval += int'(s_valid);
        end
        dead_data = 1'b0;
        check("t3_no_valid", 32'(nval), 32'd0);
        step(1'b0, 32'd0, 1'b1);
        check("t3_req", s_req, 32'd1);
        check("t3_new_addr", s_addr, 32'h0040_0100);

        // Redirect during HOLD with decode ready
        do_reset(32'h0040_0000);
        lat = 0;
        step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        step(1'b1, 32'h0040_0040, 1'b1);
        check("t4_valid", s_valid, 32'd0);
        check("t4_count", s_cnt, 32'd0);
        step(1'b0, 32'd0, 1'b1);
        check("t4_idle_req", s_req, 32'd0);
        check("t4_idle_valid", s_valid, 32'd0);
        step(1'b0, 32'd0, 1'b1);
        check("t4_req", s_req, 32'd1);
        check("t4_addr", s_addr, 32'h0040_0040);

`ifdef FETCH_TIMEOUT_EN
        // Timeout with no ack
        do_reset(32'h0040_0000);
        lat = 1000;
        for (int i = 0; i < 9; i++) step(1'b0, 32'd0, 1'b1);
        check("t5_req_last", s_req, 32'd1);
        check("t5_err_early", s_err, 32'd0);
        step(1'b0, 32'd0, 1'b1);
        check("t5_err", s_err, 32'd1);
        check("t5_req_off", s_req, 32'd0);
        force_ack = 1'b1;
        step(1'b0, 32'd0, 1'b1);
        force_ack = 1'b0;
        step(1'b0, 32'd0, 1'b1);
        check("t5_err_sticky", s_err, 32'd1);
        check("t5_req_sticky", s_req, 32'd0);
        check("t5_valid_late", s_valid, 32'd0);
        lat = 0;
`endif

        // Asynchronous reset in the middle of HOLD
        do_reset(32'h0040_0000);
        lat = 0;
        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        check("t6_hold", s_valid, 32'd1);
        rst = 1'b0;
        #1;
        check_all_zero("t6_async");
        do_reset(32'h0040_0200);
        step(1'b0, 32'd0, 1'b1);
        check("t6_idle", s_req, 32'd0);
        step(1'b0, 32'd0, 1'b1);
        check("t6_req", s_req, 32'd1);
        check("t6_addr", s_addr, 32'h0040_0200);

        // Random run: random latency, redirects and backpressure
        do_reset(32'h0040_0000);
        rand_mode = 1'b1;
        lat       = $urandom_range(0, 4);
        hs_cnt    = 0;
        gap       = 0;
        max_gap   = 0;
        for (int i = 0; i < 4000; i++) begin
            logic        r;
            logic [31:0] t;
            logic        y;
            r = ($urandom_range(0, 15) == 0);
            t = 32'h0040_0000 + (32'($urandom_range(0, 255)) << 2);
            y = ($urandom_range(0, 3) != 0);
            step(r, t, y);
            check("rand_err", s_err, 32'd0);
        end
        check("rand_progress", 32'(hs_cnt > 300), 32'd1);
        check("rand_max_gap", 32'(max_gap < 150), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
